pio_channel_arbiter: RTL and testbench

PIO_CHANNEL_ARBITER -- requirements
Module: pio_channel_arbiter

---
 rtl/pio_channel_arbiter.sv | 143 ++++++++++++++
 tb/tb_pio_channel_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_channel_arbiter.sv
// rtl/pio_channel_arbiter.sv - round-robin channel arbiter publishing one sample word to the HPS parallel-input port
// Three-state flow: IDLE picks a channel, GRANT strobes ch_ready for one cycle, HOLD keeps the word stable.
module pio_channel_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 24,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [31:0]              pp_in_axi_export,
  output logic                     xfer_pulse,
  output logic                     busy
);

  localparam int CW = $clog2(NUM_CH);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] NUM_CH_W = SW'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     last_q, last_d;
  logic [CW-1:0]     gnt_q, gnt_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  logic [31:0]       word_q, word_d;
  logic [2:0]        seq_q, seq_d;
  logic              pulse_q, pulse_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [SW-1:0]     rr_sum;
  logic [CW-1:0]     rr_try;
  logic [CW-1:0]     rr_idx;
  logic              rr_hit;
  logic [DATA_W-1:0] gnt_data;
  logic [23:0]       data_ext;

  // Walk offsets from farthest to nearest so the channel closest after last_q wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_sum = '0;
    rr_try = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_sum = {1'b0, last_q} + SW'(i);
      if (rr_sum >= NUM_CH_W) begin
        rr_sum = rr_sum - NUM_CH_W;
      end
      rr_try = rr_sum[CW-1:0];
      if (ch_valid[rr_try]) begin
        rr_hit = 1'b1;
        rr_idx = rr_try;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CW'(c) == gnt_q) begin
        gnt_data = ch_data[c*DATA_W +: DATA_W];
      end
    end
    data_ext = '0;
    data_ext[DATA_W-1:0] = gnt_data;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    ready_d = '0;
    word_d  = word_q;
    seq_d   = seq_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (enable && rr_hit) begin
          gnt_d   = rr_idx;
          ready_d = NUM_CH'(1) << rr_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // A withdrawn request leaves every published field and last_q untouched.
        if (ch_valid[gnt_q]) begin
          word_d  = {~word_q[31], seq_q, 4'(gnt_q), data_ext};
          seq_d   = seq_q + 3'd1;
          last_d  = gnt_q;
          pulse_d = 1'b1;
          cnt_d   = 16'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      last_q  <= CW'(NUM_CH - 1);
      gnt_q   <= '0;
      ready_q <= '0;
      word_q  <= '0;
      seq_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ready_q <= ready_d;
      word_q  <= word_d;
      seq_q   <= seq_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ch_ready         = ready_q;
  assign pp_in_axi_export = word_q;
  assign xfer_pulse       = pulse_q;
  assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_pio_channel_arbiter.sv
// tb/tb_pio_channel_arbiter.sv - randomized bench for pio_channel_arbiter against a transaction-level timing model
module tb_pio_channel_arbiter;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 24;
  localparam int HOLD_CYCLES = 4;

  logic                     clk      = 1'b0;
  logic                     rst      = 1'b1;
  logic                     enable   = 1'b0;
  logic [NUM_CH-1:0]        ch_valid = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data  = '0;
  logic [NUM_CH-1:0]        ch_ready;
  logic [31:0]              word;
  logic                     xfer_pulse;
  logic                     busy;

  pio_channel_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_clk(clk),
    .reset_reset(rst),
    .enable(enable),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .ch_ready(ch_ready),
    .pp_in_axi_export(word),
    .xfer_pulse(xfer_pulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: last winner, sequence, published word, pending grant and the edge at which HOLD ends.
  int          m_last;
  int          m_seq;
  logic [31:0] m_word;
  bit          m_pend;
  int          m_gch;
  int          m_hold_end;
  int          edge_n = 0;
  int          xfer_ch;

  int          log_ch[$];
  int          log_seq[$];
  int          log_tog[$];
  int          log_edge[$];
  logic [31:0] log_word[$];

  bit cont_mode   = 1'b0;
  int withdraw_ch = -1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [NUM_CH-1:0] v);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (v[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last     = NUM_CH - 1;
    m_seq      = 0;
    m_word     = '0;
    m_pend     = 1'b0;
    m_hold_end = edge_n;
  endtask

  task automatic clear_log();
    log_ch.delete();
    log_seq.delete();
    log_tog.delete();
    log_edge.delete();
    log_word.delete();
  endtask

  task automatic step();
    logic [NUM_CH-1:0]        v_at = ch_valid;
    logic                     e_at = enable;
    logic [NUM_CH*DATA_W-1:0] d_at = ch_data;
    logic [NUM_CH-1:0]        exp_ready;
    logic                     exp_pulse;
    @(posedge clk);
    #1;
    edge_n++;
    exp_ready = '0;
    exp_pulse = 1'b0;
    xfer_ch   = -1;
    if (m_pend) begin
      m_pend = 1'b0;
      if (v_at[m_gch]) begin
        m_word     = {~m_word[31], 3'(m_seq), 4'(m_gch), d_at[m_gch*DATA_W +: DATA_W]};
        m_seq      = (m_seq + 1) % 8;
        m_last     = m_gch;
        exp_pulse  = 1'b1;
        m_hold_end = edge_n + HOLD_CYCLES;
        xfer_ch    = m_gch;
        log_ch.push_back(int'(word[27:24]));
        log_seq.push_back(int'(word[30:28]));
        log_tog.push_back(int'(word[31]));
        log_edge.push_back(edge_n);
        log_word.push_back(word);
      end else begin
        m_hold_end = edge_n;
      end
    end else if (edge_n > m_hold_end && e_at && v_at != '0) begin
      m_gch     = rr_pick(m_last, v_at);
      m_pend    = 1'b1;
      exp_ready = NUM_CH'(1) << m_gch;
    end
    check_eq("ch_ready", 32'(ch_ready), 32'(exp_ready));
    check_eq("export", word, m_word);
    check_eq("xfer_pulse", 32'(xfer_pulse), 32'(exp_pulse));
    check_eq("busy", 32'(busy), 32'(m_pend || edge_n < m_hold_end));
    if (xfer_ch >= 0) begin
      if (cont_mode) ch_data[xfer_ch*DATA_W +: DATA_W] = DATA_W'($urandom);
      else           ch_valid[xfer_ch] = 1'b0;
    end
    if (withdraw_ch >= 0 && ch_ready[withdraw_ch]) begin
      ch_valid[withdraw_ch] = 1'b0;
      withdraw_ch = -1;
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_eq("rst_ready", 32'(ch_ready), 32'd0);
    check_eq("rst_export", word, 32'd0);
    check_eq("rst_pulse", 32'(xfer_pulse), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_until_xfers(input int n, input int budget);
    for (int k = 0; k < budget && log_ch.size() < n; k++) step();
  endtask

  task automatic load_data();
    for (int c = 0; c < NUM_CH; c++) ch_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  initial begin
    int          busy_cnt;
    int          rdy_cnt;
    int          pulse_cnt;
    logic [31:0] word_before;

    @(posedge clk);
    #1;
    check_eq("rst0_ready", 32'(ch_ready), 32'd0);
    check_eq("rst0_export", word, 32'd0);
    check_eq("rst0_pulse", 32'(xfer_pulse), 32'd0);
    check_eq("rst0_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    enable = 1'b1;

    // Single request on channel 2.
    ch_data[2*DATA_W +: DATA_W] = 24'hABCDEF;
    ch_valid = 4'b0100;
    busy_cnt = 0; rdy_cnt = 0; pulse_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (busy) busy_cnt++;
      if (ch_ready != '0) rdy_cnt++;
      if (xfer_pulse) pulse_cnt++;
    end
    check_eq("s1_count", 32'(log_word.size()), 32'd1);
    check_eq("s1_word", (log_word.size() > 0) ? log_word[0] : 32'hDEAD_BEEF, 32'h82ABCDEF);
    check_eq("s1_busy_cycles", 32'(busy_cnt), 32'(HOLD_CYCLES + 1));
    check_eq("s1_ready_cycles", 32'(rdy_cnt), 32'd1);
    check_eq("s1_pulse_cycles", 32'(pulse_cnt), 32'd1);

    // Fairness with all channels continuously valid.
    do_reset();
    clear_log();
    cont_mode = 1'b1;
    load_data();
    ch_valid = 4'b1111;
    run_until_xfers(5, 80);
    check_eq("s2_count", 32'(log_ch.size()), 32'd5);
    for (int i = 0; i < log_ch.size(); i++) begin
      check_eq("s2_order", 32'(log_ch[i]), 32'(i % NUM_CH));
      check_eq("s2_seq", 32'(log_seq[i]), 32'(i));
      check_eq("s2_toggle", 32'(log_tog[i]), 32'((i % 2) == 0));
      if (i > 0) check_eq("s2_spacing", 32'(log_edge[i] - log_edge[i-1]), 32'(HOLD_CYCLES + 2));
    end
    cont_mode = 1'b0;
    ch_valid = '0;
    run(8);

    // Withdrawal: channel 0 first to pin last, then channel 1 withdraws once.
    clear_log();
    load_data();
    ch_valid = 4'b0001;
    run_until_xfers(1, 10);
    run(6);
    word_before = word;
    withdraw_ch = 1;
    ch_valid = 4'b0010;
    pulse_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (xfer_pulse) pulse_cnt++;
    end
    check_eq("s3_export_kept", word, word_before);
    check_eq("s3_no_pulse", 32'(pulse_cnt), 32'd0);
    check_eq("s3_idle", 32'(busy), 32'd0);
    clear_log();
    load_data();
    ch_valid = 4'b0110;
    run_until_xfers(1, 10);
    check_eq("s3_regrant", (log_ch.size() > 0) ? 32'(log_ch[0]) : 32'hFFFF_FFFF, 32'd1);
    run(8);

    // Enable gating.
    enable = 1'b0;
    load_data();
    ch_valid = 4'b1010;
    rdy_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (ch_ready != '0) rdy_cnt++;
    end
    check_eq("s4_no_grant_disabled", 32'(rdy_cnt), 32'd0);
    clear_log();
    enable = 1'b1;
    run_until_xfers(1, 10);
    enable = 1'b0;
    rdy_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ch_ready != '0) rdy_cnt++;
    end
    check_eq("s4_xfer_before_gate", 32'(log_ch.size()), 32'd1);
    check_eq("s4_no_grant_after_hold", 32'(rdy_cnt), 32'd0);
    check_eq("s4_hold_done", 32'(busy), 32'd0);
    enable = 1'b1;
    run(12);
    ch_valid = '0;
    run(4);

    // Sequence wrap over nine transfers, then reset in the middle of HOLD.
    do_reset();
    clear_log();
    cont_mode = 1'b1;
    load_data();
    ch_valid = 4'b1111;
    run_until_xfers(9, 120);
    check_eq("s5_count", 32'(log_seq.size()), 32'd9);
    for (int i = 0; i < log_seq.size(); i++) check_eq("s5_seq", 32'(log_seq[i]), 32'(i % 8));
    cont_mode = 1'b0;
    run(2);
    check_eq("s5_in_hold", 32'(busy), 32'd1);
    do_reset();
    clear_log();
    ch_valid = 4'b1111;
    run_until_xfers(1, 10);
    check_eq("s5_first_after_reset", (log_ch.size() > 0) ? 32'(log_ch[0]) : 32'hFFFF_FFFF, 32'd0);
    ch_valid = '0;
    run(8);

    // Random traffic with withdrawals, enable toggling and occasional resets.
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom % 8) != 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!ch_valid[c] && ($urandom % 4) == 0) begin
          ch_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
          ch_valid[c] = 1'b1;
        end
      end
      if (withdraw_ch < 0 && ($urandom % 6) == 0) withdraw_ch = int'($urandom % NUM_CH);
      step();
      if (($urandom % 150) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
